// File: rtl/ifc_pkg.sv
// Shared definitions for the IFC slave bridge.
//   state_e     : bridge FSM states
//   AddrWDefault: default register address width
//   DataWDefault: default IFC data width
//   CtrlIdle    : idle level of the {avd, oe_b, we_b, cs} strobe vector
//   bitrev()    : reverses the low w bits of a 32-bit value (w <= 32)
package ifc_pkg;

  localparam int unsigned AddrWDefault = 8;
  localparam int unsigned DataWDefault = 16;

  // Strobe vector packing is {avd, oe_b, we_b, cs}; idle is avd low, the rest high.
  localparam logic [3:0] CtrlIdle = 4'b0111;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StFetch,
    StCapt,
    StReady,
    StWrite,
    StRead
  } state_e;

  // IFC numbers bit 0 as the MSB, so every crossing between the pins and the
  // register bank goes through this.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned w);
    logic [31:0] r;
    r = {<<{x}};
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/ifc_slave_bridge_if.sv
// Bundle of the IFC strobes/address and the register-bank strobes.
//   slave : the bridge (samples IFC strobes and reg_rdata, drives reg_* and bus_err)
//   master: the host pins plus the register bank on the other side
// The muxed ifc_ad bus is deliberately not in here; it stays a plain inout on the
// bridge so the tri-state driver sits right at the pin boundary.
interface ifc_slave_bridge_if #(
  parameter int unsigned ADDR_W = ifc_pkg::AddrWDefault,
  parameter int unsigned DATA_W = ifc_pkg::DataWDefault
) ();

  logic              ifc_cs;
  logic              ifc_we_b;
  logic              ifc_oe_b;
  logic              ifc_avd;
  logic [ADDR_W-1:0] ifc_addr;

  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_rd_done;
  logic              bus_err;

  modport slave (
    input  ifc_cs, ifc_we_b, ifc_oe_b, ifc_avd, ifc_addr, reg_rdata,
    output reg_addr, reg_wdata, reg_wr, reg_rd, reg_rd_done, bus_err
  );

  modport master (
    output ifc_cs, ifc_we_b, ifc_oe_b, ifc_avd, ifc_addr, reg_rdata,
    input  reg_addr, reg_wdata, reg_wr, reg_rd, reg_rd_done, bus_err
  );

endinterface

// File: rtl/ifc_sync.sv
// Multi-flop synchroniser for a bundle of asynchronous bits.
//   clk_i   : destination clock
//   rst_i   : asynchronous reset, active-high; loads ResetVal into every stage
//   d_i     : asynchronous input bits
//   q_o     : synchronised bits, Stages clocks behind d_i
module ifc_sync #(
  parameter int unsigned       Width    = 1,
  parameter int unsigned       Stages   = 2,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Stages];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Stages; i++) stage_q[i] <= ResetVal;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/ifc_slave_bridge.sv
// IFC bus slave front-end behind the CPLD's IFC pins.
//   clock_50MHz : system clock
//   reset       : asynchronous reset, active-high
//   bus         : IFC strobes/latched address in, register-bank strobes out
//   ifc_ad      : muxed, bit-reversed address/data bus (sampled for writes,
//                 driven with prefetched data during host reads)
// Every address phase prefetches the register so the short oe_b window is met;
// writes and reads become single-cycle reg_wr / reg_rd_done strobes.
module ifc_slave_bridge
  import ifc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = AddrWDefault,
  parameter int unsigned DATA_W      = DataWDefault
) (
  input  logic               clock_50MHz,
  input  logic               reset,
  ifc_slave_bridge_if.slave  bus,
  inout  wire  [DATA_W-1:0]  ifc_ad
);

  logic [3:0]        ctrl_raw, ctrl_s;
  logic [DATA_W-1:0] ad_s;

  assign ctrl_raw = {bus.ifc_avd, bus.ifc_oe_b, bus.ifc_we_b, bus.ifc_cs};

  ifc_sync #(
    .Width    (4),
    .Stages   (SYNC_STAGES),
    .ResetVal (CtrlIdle)
  ) u_ctrl_sync (
    .clk_i (clock_50MHz),
    .rst_i (reset),
    .d_i   (ctrl_raw),
    .q_o   (ctrl_s)
  );

  ifc_sync #(
    .Width    (DATA_W),
    .Stages   (SYNC_STAGES),
    .ResetVal ({DATA_W{1'b0}})
  ) u_ad_sync (
    .clk_i (clock_50MHz),
    .rst_i (reset),
    .d_i   (ifc_ad),
    .q_o   (ad_s)
  );

  state_e            state_q, state_d;
  logic [3:0]        ctrl_p_q;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic              rd_done_q, rd_done_d;
  logic              bus_err_q, bus_err_d;

  logic cs_s, we_s, oe_s, avd_s;
  logic cs_p, we_p, oe_p, avd_p;
  assign {avd_s, oe_s, we_s, cs_s} = ctrl_s;
  assign {avd_p, oe_p, we_p, cs_p} = ctrl_p_q;

  logic avd_rise, avd_fall, we_rise, oe_rise, cs_rise, rd_req, rd_req_start;
  assign avd_rise     = avd_s & ~avd_p;
  assign avd_fall     = ~avd_s & avd_p;
  assign we_rise      = we_s & ~we_p;
  assign oe_rise      = oe_s & ~oe_p;
  assign cs_rise      = cs_s & ~cs_p;
  assign rd_req       = ~cs_s & ~oe_s;
  assign rd_req_start = rd_req & ~(~cs_p & ~oe_p);

  logic [ADDR_W-1:0] addr_rev;
  logic [DATA_W-1:0] ad_rev, rdata_rev;
  assign addr_rev  = ADDR_W'(bitrev(32'(bus.ifc_addr), ADDR_W));
  assign ad_rev    = DATA_W'(bitrev(32'(ad_s), DATA_W));
  assign rdata_rev = DATA_W'(bitrev(32'(bus.reg_rdata), DATA_W));

  always_comb begin
    state_d     = state_q;
    reg_addr_d  = reg_addr_q;
    wdata_d     = wdata_q;
    reg_wdata_d = reg_wdata_q;
    rdata_d     = rdata_q;
    rd_valid_d  = rd_valid_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    rd_done_d   = 1'b0;
    // Host opened a read before the prefetched data could be on the bus.
    bus_err_d   = rd_req_start & (state_q inside {StIdle, StAddr, StFetch, StCapt});

    unique case (state_q)
      StIdle: begin
        if (avd_rise) state_d = StAddr;
      end
      StAddr: begin
        if (avd_fall) begin
          reg_addr_d = addr_rev;
          reg_rd_d   = 1'b1;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        state_d = StCapt;
      end
      StCapt: begin
        rdata_d    = rdata_rev;
        rd_valid_d = 1'b1;
        state_d    = StReady;
      end
      StReady: begin
        if (avd_rise) begin
          // New address phase: drop the stale prefetch.
          rd_valid_d = 1'b0;
          state_d    = StAddr;
        end else if (!cs_s && !we_s) begin
          state_d = StWrite;
        end else if (rd_req) begin
          state_d = StRead;
        end
      end
      StWrite: begin
        // Track the bus every cycle; the commit uses the value from before the
        // synchronised we_b edge, i.e. data captured while we_b was still low.
        wdata_d = ad_rev;
        if (we_rise || cs_rise) begin
          reg_wdata_d = wdata_q;
          reg_wr_d    = 1'b1;
          rd_valid_d  = 1'b0;
          state_d     = StIdle;
        end
      end
      StRead: begin
        if (oe_rise || cs_rise) begin
          rd_done_d  = 1'b1;
          rd_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ctrl_p_q    <= CtrlIdle;
      reg_addr_q  <= '0;
      wdata_q     <= '0;
      reg_wdata_q <= '0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      rd_done_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_p_q    <= ctrl_s;
      reg_addr_q  <= reg_addr_d;
      wdata_q     <= wdata_d;
      reg_wdata_q <= reg_wdata_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= rd_valid_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      rd_done_q   <= rd_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_wdata   = reg_wdata_q;
  assign bus.reg_wr      = reg_wr_q;
  assign bus.reg_rd      = reg_rd_q;
  assign bus.reg_rd_done = rd_done_q;
  assign bus.bus_err     = bus_err_q;

  // Gated on the raw pins so the bus is released the instant oe_b or cs deasserts.
  assign ifc_ad = (!bus.ifc_cs && !bus.ifc_oe_b && rd_valid_q) ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ifc_slave_bridge.sv
// Self-checking bench for ifc_slave_bridge. Expected strobes are scheduled per cycle
// from the host stimulus using the documented latencies; a negedge process compares.
module tb_ifc_slave_bridge;

  localparam int unsigned SYNC = 2;
  localparam int NCYC = 1024;
  localparam int Never = 1 << 30;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  ifc_slave_bridge_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  wire  [15:0] ifc_ad;
  logic        drv_en;
  logic [15:0] drv_val;
  assign ifc_ad = drv_en ? drv_val : 16'hzzzz;

  ifc_slave_bridge #(
    .SYNC_STAGES (SYNC),
    .ADDR_W      (8),
    .DATA_W      (16)
  ) dut (
    .clock_50MHz (clk),
    .reset       (rst),
    .bus         (bus),
    .ifc_ad      (ifc_ad)
  );

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  function automatic logic [15:0] bank_val(input logic [7:0] a);
    if (a == 8'd34) return 16'hA5C3;
    if (a == 8'd0) return 16'h0001;
    return {8'h5A, a};
  endfunction

  // Register bank: registered, side-effect-free read.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.reg_rdata <= '0;
    else if (bus.reg_rd) bus.reg_rdata <= bank_val(bus.reg_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: what must appear after posedge k, sampled at the following negedge.
  bit          exp_wr   [NCYC];
  bit          exp_rd   [NCYC];
  bit          exp_done [NCYC];
  bit          exp_err  [NCYC];
  logic [7:0]  exp_wr_addr [NCYC];
  logic [15:0] exp_wr_data [NCYC];
  logic [7:0]  exp_rd_addr [NCYC];
  int          rdy_at = Never;
  logic [7:0]  cur_addr = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic clear_from(input int from);
    for (int k = from; k < NCYC; k++) begin
      exp_wr[k]   = 1'b0;
      exp_rd[k]   = 1'b0;
      exp_done[k] = 1'b0;
      exp_err[k]  = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      check("reg_wr", 32'(bus.reg_wr), 32'(exp_wr[cyc]));
      check("reg_rd", 32'(bus.reg_rd), 32'(exp_rd[cyc]));
      check("reg_rd_done", 32'(bus.reg_rd_done), 32'(exp_done[cyc]));
      check("bus_err", 32'(bus.bus_err), 32'(exp_err[cyc]));
      check("wr_rd_excl", 32'(bus.reg_wr & bus.reg_rd), 32'd0);
      if (exp_wr[cyc]) begin
        check("wr_addr", 32'(bus.reg_addr), 32'(exp_wr_addr[cyc]));
        check("wr_data", 32'(bus.reg_wdata), 32'(exp_wr_data[cyc]));
      end
      if (exp_rd[cyc]) check("rd_addr", 32'(bus.reg_addr), 32'(exp_rd_addr[cyc]));
      if (!drv_en) begin
        if (!bus.ifc_cs && !bus.ifc_oe_b && cyc >= rdy_at) begin
          check("ifc_ad", 32'(ifc_ad), 32'(rev16(bank_val(cur_addr))));
        end else begin
          vectors++;
          if (!(ifc_ad === 16'hzzzz || ifc_ad === 16'h0000)) begin
            miscompares++;
            $display("FAIL ifc_ad_release at cycle %0d: got %h, expected undriven", cyc, ifc_ad);
          end
        end
      end
    end
  end

  // Advance n clocks and land 5 ns after the edge, where all stimulus changes.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic addr_phase(input logic [7:0] a, output int n_fall);
    bus.ifc_addr = rev8(a);
    drv_val      = {8'h00, rev8(a)};
    drv_en       = 1'b1;
    bus.ifc_avd  = 1'b1;
    rdy_at       = Never;
    step(3);
    bus.ifc_avd = 1'b0;
    drv_en      = 1'b0;
    n_fall      = cyc;
    cur_addr    = a;
    if (n_fall + SYNC + 1 < NCYC) begin
      exp_rd[n_fall + SYNC + 1]      = 1'b1;
      exp_rd_addr[n_fall + SYNC + 1] = a;
    end
    rdy_at = n_fall + SYNC + 3;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d);
    int n, m;
    step(2);
    addr_phase(a, n);
    step(2);
    bus.ifc_cs   = 1'b0;
    bus.ifc_we_b = 1'b0;
    drv_val      = rev16(d);
    drv_en       = 1'b1;
    step(4);
    bus.ifc_we_b = 1'b1;
    m = cyc;
    if (m + SYNC + 1 < NCYC) begin
      exp_wr[m + SYNC + 1]      = 1'b1;
      exp_wr_addr[m + SYNC + 1] = a;
      exp_wr_data[m + SYNC + 1] = d;
    end
    step(1);
    bus.ifc_cs = 1'b1;
    drv_en     = 1'b0;
    step(SYNC + 2);
  endtask

  task automatic host_read(input logic [7:0] a, input int oe_dly, input int oe_len,
                           input bit pin_en, input logic [15:0] pin_val);
    int n, e, o;
    step(2);
    addr_phase(a, n);
    step(oe_dly);
    bus.ifc_cs   = 1'b0;
    bus.ifc_oe_b = 1'b0;
    e = cyc;
    // Read opened before the prefetch could reach the bus.
    if (e + SYNC < n + SYNC + 3 && e + SYNC + 1 < NCYC) exp_err[e + SYNC + 1] = 1'b1;
    if (pin_en) begin
      #30;
      check("pin_data", 32'(ifc_ad), 32'(pin_val));
      step(oe_len - 1);
    end else begin
      step(oe_len);
    end
    bus.ifc_oe_b = 1'b1;
    bus.ifc_cs   = 1'b1;
    o = cyc;
    if (o + SYNC + 1 < NCYC) exp_done[o + SYNC + 1] = 1'b1;
    step(SYNC + 2);
  endtask

  initial begin
    int n1, n2;
    rst          = 1'b1;
    bus.ifc_cs   = 1'b1;
    bus.ifc_we_b = 1'b1;
    bus.ifc_oe_b = 1'b1;
    bus.ifc_avd  = 1'b0;
    bus.ifc_addr = '0;
    drv_en       = 1'b0;
    drv_val      = '0;
    step(3);
    check("rst_reg_addr", 32'(bus.reg_addr), 32'h0);
    check("rst_reg_wdata", 32'(bus.reg_wdata), 32'h0);
    check("rst_reg_wr", 32'(bus.reg_wr), 32'h0);
    check("rst_reg_rd", 32'(bus.reg_rd), 32'h0);
    check("rst_bus_err", 32'(bus.bus_err), 32'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Write 0x0123 to register 34.
    host_write(8'd34, 16'h0123);
    check("lit_wr_addr", 32'(bus.reg_addr), 32'h22);
    check("lit_wr_data", 32'(bus.reg_wdata), 32'h0123);

    // Read register 34: bus must carry rev(0xA5C3) 30 ns into oe_b low.
    host_read(8'd34, 5, 2, 1'b1, 16'hC3A5);

    // Back-to-back: register 0 returns 0x0001, i.e. 0x8000 on the pins.
    host_read(8'd0, 5, 2, 1'b1, 16'h8000);

    // Early oe: cs/oe_b asserted 20 ns after avd falls, held until data arrives.
    host_read(8'd7, 1, 7, 1'b0, 16'h0000);

    // Abandon: second address phase before any cs.
    step(2);
    addr_phase(8'd9, n1);
    step(4);
    addr_phase(8'd5, n2);
    step(SYNC + 4);
    check("lit_abandon_addr", 32'(bus.reg_addr), 32'h05);

    // Reset while a write is in progress.
    step(2);
    addr_phase(8'h3C, n1);
    step(2);
    bus.ifc_cs   = 1'b0;
    bus.ifc_we_b = 1'b0;
    drv_val      = rev16(16'hDEAD);
    drv_en       = 1'b1;
    step(4);
    rst    = 1'b1;
    rdy_at = Never;
    clear_from(cyc);
    #2;
    check("midrst_reg_addr", 32'(bus.reg_addr), 32'h0);
    check("midrst_reg_wdata", 32'(bus.reg_wdata), 32'h0);
    check("midrst_reg_wr", 32'(bus.reg_wr), 32'h0);
    check("midrst_reg_rd_done", 32'(bus.reg_rd_done), 32'h0);
    step(1);
    bus.ifc_we_b = 1'b1;
    bus.ifc_cs   = 1'b1;
    drv_en       = 1'b0;
    step(2);
    rst = 1'b0;
    host_write(8'h3C, 16'hBEEF);
    check("lit_post_rst_data", 32'(bus.reg_wdata), 32'hBEEF);
    check("lit_post_rst_addr", 32'(bus.reg_addr), 32'h3C);

    step(4);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
